bcd_stopwatch_disp: RTL and testbench

//  Downstream consumer of the clock-divider stage. Counts the divider's slow tick as a

---
 rtl/eld_disp_pkg.sv | 27 ++
 rtl/bcd_stopwatch_disp_if.sv | 24 ++
 rtl/bcd_digit.sv | 26 ++
 rtl/bcd_stopwatch_disp.sv | 101 ++++++++++
 tb/tb_bcd_stopwatch_disp.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/eld_disp_pkg.sv
// Shared display types: stopwatch FSM state, blank pattern and 7-segment decoder.
package eld_disp_pkg;

  typedef enum logic {STOPPED, RUNNING} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_disp_if.sv
// Control pulses in, count/status/display out between the stopwatch and its host.
interface bcd_stopwatch_disp_if #(parameter int unsigned NDIG = 4);

  logic                  tick;
  logic                  btn_ss;
  logic                  btn_clr;
  logic                  up_dn;
  logic [4*NDIG-1:0]     bcd;
  logic                  wrap;
  logic                  running;
  logic [6:0]            seg;
  logic [NDIG-1:0]       an;

  modport master (
    output tick, btn_ss, btn_clr, up_dn,
    input  bcd, wrap, running, seg, an
  );

  modport slave (
    input  tick, btn_ss, btn_clr, up_dn,
    output bcd, wrap, running, seg, an
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: holds 0..9, counts up or down when enabled, flags roll-over.
module bcd_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry_out
);

  // Combinational so the whole chain ripples within one cycle
  assign carry_out = en & (up_dn ? (digit == 4'd9) : (digit == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (en) begin
      if (up_dn) digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      else       digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_disp.sv
// NDIG-digit BCD up/down stopwatch with multiplexed common-anode 7-segment output.
// Define BLANK_LEADING_ZERO_EN to suppress leading zeros on the display.
module bcd_stopwatch_disp #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                 clk,
  input logic                 rst_n,
  bcd_stopwatch_disp_if.slave bus
);
  import eld_disp_pkg::*;

  localparam int unsigned IW = $clog2(NDIG);
  localparam int unsigned CW = $clog2(SCAN_DIV);

  state_t                 state;
  logic                   running_q;
  logic                   wrap_q;
  logic [CW-1:0]          scan_cnt;
  logic [IW-1:0]          scan_idx;
  logic [6:0]             seg_q;
  logic [NDIG-1:0]        an_q;
  logic [6:0]             seg_nxt;
  logic                   count_en;
  logic [NDIG-1:0]        en;
  logic [NDIG-1:0]        carry;
  logic [NDIG-1:0][3:0]   dig;

  assign count_en = (state == RUNNING) & bus.tick;
  assign en       = {carry[NDIG-2:0], count_en};

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en[i]),
      .up_dn     (bus.up_dn),
      .clr       (bus.btn_clr),
      .digit     (dig[i]),
      .carry_out (carry[i])
    );
  end

`ifdef BLANK_LEADING_ZERO_EN
  logic [NDIG-1:0] lead_zero;

  // lead_zero[i]: digit i and every digit above it are zero
  always_comb begin : p_lead_zero
    logic z;
    z         = 1'b1;
    lead_zero = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      z            = z && (dig[i] == 4'd0);
      lead_zero[i] = z;
    end
  end

  always_comb begin
    seg_nxt = seg7_decode(dig[scan_idx]);
    if ((scan_idx != '0) && lead_zero[scan_idx]) seg_nxt = SEG_BLANK;
  end
`else
  always_comb begin
    seg_nxt = seg7_decode(dig[scan_idx]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STOPPED;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      scan_cnt  <= '0;
      scan_idx  <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
    end else begin
      if (bus.btn_ss) begin
        state     <= (state == RUNNING) ? STOPPED : RUNNING;
        running_q <= (state == STOPPED);
      end
      wrap_q <= carry[NDIG-1] & ~bus.btn_clr;
      // Digit scan: dwell SCAN_DIV clocks per anode
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(NDIG - 1)) ? '0 : scan_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      seg_q <= seg_nxt;
      an_q  <= ~(NDIG'(1) << scan_idx);
    end
  end

  assign bus.bcd     = dig;
  assign bus.wrap    = wrap_q;
  assign bus.running = running_q;
  assign bus.seg     = seg_q;
  assign bus.an      = an_q;

endmodule

// File: tb/tb_bcd_stopwatch_disp.sv
// Directed bench for bcd_stopwatch_disp: vector table plus scan, wrap and reset sequences.
module tb_bcd_stopwatch_disp;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bcd_stopwatch_disp_if #(.NDIG(4)) bus ();

  bcd_stopwatch_disp #(.NDIG(4), .SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic        ss;
    logic        clr;
    logic        ud;
    logic [15:0] bcd;
    logic        wrap;
    logic        run;
  } vec_t;

  vec_t vec [16];

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic t, input logic ss, input logic clr, input logic ud);
    bus.tick    = t;
    bus.btn_ss  = ss;
    bus.btn_clr = clr;
    bus.up_dn   = ud;
    @(posedge clk);
    #1;
    bus.tick    = 1'b0;
    bus.btn_ss  = 1'b0;
    bus.btn_clr = 1'b0;
  endtask

  task automatic ticks(input int n, input logic ud);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, ud);
  endtask

  task automatic check_scan(input logic [15:0] val, input string tag);
    int guard;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int j;
    guard = 0;
    while (bus.an !== 4'h7 && guard < 40) begin cyc(0, 0, 0, 1); guard++; end
    while (bus.an !== 4'hE && guard < 40) begin cyc(0, 0, 0, 1); guard++; end
    if (guard >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_sync: an=%h never reached scan start", tag, bus.an);
      return;
    end
    for (int k = 0; k < 16; k++) begin
      j       = k / 4;
      exp_an  = ~(4'b0001 << j);
      exp_seg = ref_seg(val[4*j +: 4]);
`ifdef BLANK_LEADING_ZERO_EN
      if (j > 0 && (val >> (4*j)) == 16'h0) exp_seg = 7'h7F;
`endif
      chk($sformatf("%s_an%0d", tag, k), 32'(bus.an), 32'(exp_an));
      chk($sformatf("%s_seg%0d", tag, k), 32'(bus.seg), 32'(exp_seg));
      cyc(0, 0, 0, 1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //        tick ss clr ud  bcd      wrap run
    vec[0]  = '{1, 0, 0, 1, 16'h0000, 0, 0};
    vec[1]  = '{0, 1, 0, 1, 16'h0000, 0, 1};
    vec[2]  = '{1, 0, 0, 1, 16'h0001, 0, 1};
    vec[3]  = '{1, 0, 0, 1, 16'h0002, 0, 1};
    vec[4]  = '{1, 1, 0, 1, 16'h0003, 0, 0};
    vec[5]  = '{1, 0, 0, 1, 16'h0003, 0, 0};
    vec[6]  = '{1, 1, 0, 1, 16'h0003, 0, 1};
    vec[7]  = '{1, 0, 0, 0, 16'h0002, 0, 1};
    vec[8]  = '{1, 0, 0, 0, 16'h0001, 0, 1};
    vec[9]  = '{0, 0, 1, 0, 16'h0000, 0, 1};
    vec[10] = '{1, 0, 0, 0, 16'h9999, 1, 1};
    vec[11] = '{0, 0, 0, 0, 16'h9999, 0, 1};
    vec[12] = '{1, 0, 0, 1, 16'h0000, 1, 1};
    vec[13] = '{1, 0, 0, 1, 16'h0001, 0, 1};
    vec[14] = '{1, 1, 1, 1, 16'h0000, 0, 0};
    vec[15] = '{1, 0, 0, 1, 16'h0000, 0, 0};

    bus.tick = 0; bus.btn_ss = 0; bus.btn_clr = 0; bus.up_dn = 1;
    rst_n = 1'b0;
    #12;
    chk("rst_bcd",  32'(bus.bcd),     32'h0000);
    chk("rst_an",   32'(bus.an),      32'hF);
    chk("rst_seg",  32'(bus.seg),     32'h7F);
    chk("rst_run",  32'(bus.running), 32'h0);
    chk("rst_wrap", 32'(bus.wrap),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cyc(vec[i].tick, vec[i].ss, vec[i].clr, vec[i].ud);
      chk($sformatf("v%0d_bcd", i),  32'(bus.bcd),     32'(vec[i].bcd));
      chk($sformatf("v%0d_wrap", i), 32'(bus.wrap),    32'(vec[i].wrap));
      chk($sformatf("v%0d_run", i),  32'(bus.running), 32'(vec[i].run));
    end

    // Count while running, hold while stopped
    cyc(0, 1, 0, 1);
    ticks(12, 1);
    chk("run12_bcd", 32'(bus.bcd), 32'h0012);
    cyc(0, 1, 0, 1);
    chk("stop_run", 32'(bus.running), 32'h0);
    ticks(3, 1);
    chk("stop3_bcd", 32'(bus.bcd), 32'h0012);

    // Multi-digit carry and full wrap in both directions
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    ticks(99, 1);
    chk("c99_bcd", 32'(bus.bcd), 32'h0099);
    ticks(1, 1);
    chk("c100_bcd",  32'(bus.bcd),  32'h0100);
    chk("c100_wrap", 32'(bus.wrap), 32'h0);
    cyc(0, 0, 1, 1);
    ticks(1, 0);
    chk("dn_wrap_bcd", 32'(bus.bcd),  32'h9999);
    chk("dn_wrap",     32'(bus.wrap), 32'h1);
    cyc(0, 0, 0, 1);
    chk("dn_wrap_end", 32'(bus.wrap), 32'h0);
    ticks(1, 1);
    chk("up_wrap_bcd", 32'(bus.bcd),  32'h0000);
    chk("up_wrap",     32'(bus.wrap), 32'h1);
    cyc(0, 0, 0, 1);
    chk("up_wrap_end", 32'(bus.wrap), 32'h0);
    cyc(1, 0, 1, 0);
    chk("clr_tick_bcd",  32'(bus.bcd),  32'h0000);
    chk("clr_tick_wrap", 32'(bus.wrap), 32'h0);

    // Display scan of 1234
    cyc(0, 0, 1, 1);
    ticks(1234, 1);
    cyc(0, 1, 0, 1);
    chk("p1234_bcd", 32'(bus.bcd), 32'h1234);
    check_scan(16'h1234, "s1234");

    // Leading zeros on 0007 and 0000
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    ticks(7, 1);
    cyc(0, 1, 0, 1);
    chk("p0007_bcd", 32'(bus.bcd), 32'h0007);
    check_scan(16'h0007, "s0007");
    cyc(0, 0, 1, 1);
    check_scan(16'h0000, "s0000");

    // Asynchronous reset mid-count
    cyc(0, 1, 0, 1);
    ticks(42, 1);
    chk("p0042_bcd", 32'(bus.bcd), 32'h0042);
    bus.tick = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd",  32'(bus.bcd),     32'h0000);
    chk("mid_rst_an",   32'(bus.an),      32'hF);
    chk("mid_rst_seg",  32'(bus.seg),     32'h7F);
    chk("mid_rst_run",  32'(bus.running), 32'h0);
    chk("mid_rst_wrap", 32'(bus.wrap),    32'h0);
    bus.tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1);
    chk("post_rst_an",  32'(bus.an),      32'hE);
    chk("post_rst_seg", 32'(bus.seg),     32'h40);
    chk("post_rst_bcd", 32'(bus.bcd),     32'h0000);
    chk("post_rst_run", 32'(bus.running), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
